button_events: RTL and testbench
================================

Name: button_events

Overview:
- Input-side counterpart to the display/sound output path of the clock top level.
- Takes the five raw push buttons (up, down, left, right, middle) and synchronises and debounces them.
- Converts them into clean single-cycle event pulses for mode selection, time setting and the alarm.
- Adds long-press detection and auto-repeat so held up/down buttons step values continuously.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz); must be >= 2.
- HOLD_CYCLES, 50_000_000: cycles a debounced press must persist before long-press/auto-repeat starts (500 ms); must be >= 2.
- REPEAT_CYCLES, 10_000_000: auto-repeat interval once repeating (100 ms); must be >= 2.
- REPEAT_MASK, 5'b00011: per-button enable for auto-repeat on step_pulse (default: up, down only).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_raw  input  5  raw buttons, active-high, asynchronous; bit0 up, bit1 down, bit2 left, bit3 right, bit4 middle.
- btn_level  output  5  debounced button levels.
- press_pulse  output  5  one-cycle pulse on debounced rising edge.
- release_pulse  output  5  one-cycle pulse on debounced falling edge.
- long_pulse  output  5  one-cycle pulse when a press reaches HOLD_CYCLES.
- step_pulse  output  5  press_pulse OR auto-repeat pulse (auto-repeat only where REPEAT_MASK bit set).

Behaviour:
- Reset: all outputs 0; synchroniser flops, counters and FSMs cleared to IDLE.
  - Reset is asynchronous assert; deassert takes effect on the next clk edge.
  - Reset mid-press: after release of rst_n a still-held button is treated as a new press (full debounce, then press_pulse).
- Synchroniser: 2-flop chain per bit (s1, s2), reset 0. Nothing downstream samples btn_raw directly.
- Debounce, per bit, with counter width clog2(DEBOUNCE_CYCLES):
  - s2 == btn_level: counter <= 0.
  - s2 != btn_level: counter increments.
  - On the cycle counter == DEBOUNCE_CYCLES-1 with s2 still differing: btn_level <= s2, counter <= 0.
  - Any glitch back to btn_level before then restarts the count.
- Latency: raw level held from clock edge E is reflected in btn_level at edge E+DEBOUNCE_CYCLES+1; press_pulse/release_pulse are registered on that same edge.
- press_pulse, release_pulse: each high exactly one cycle. A bit can never assert both in the same cycle.
- Hold FSM, per bit, with shared-width counter sized for max(HOLD_CYCLES, REPEAT_CYCLES):
  - IDLE: on debounced rise -> PRESSED, cnt <= 0.
  - PRESSED: cnt increments. At cnt == HOLD_CYCLES-1 -> REPEATING, cnt <= 0, long_pulse <= 1 for one cycle; auto-repeat pulse fires if the mask bit is set.
  - REPEATING: cnt increments. At cnt == REPEAT_CYCLES-1, cnt <= 0 and an auto-repeat pulse fires if the mask bit is set. Continues until release.
  - Any state: debounced fall -> IDLE, cnt <= 0, no further long/repeat pulses. Release wins over a coincident hold/repeat terminal count (no pulse that cycle).
- step_pulse = press_pulse | (repeat & REPEAT_MASK), registered. long_pulse fires for all bits regardless of mask.
- Bits are fully independent: simultaneous presses on several buttons produce simultaneous pulses on each bit; no priority or encoding.
- Counters saturate-free by construction (always cleared at terminal count); no wrap-around reachable.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8):
- Clean press/release:
  - Stimulus: btn_raw[0] high at edge 10, low at edge 60.
  - Response: btn_level[0] and press_pulse[0] rise at edge 15, press_pulse for 1 cycle, step_pulse[0] for 1 cycle at edge 15.
  - Response: release_pulse[0] at edge 65, btn_level[0] low at edge 65.
- Bounce rejection:
  - Stimulus: btn_raw[2] toggles every 2 cycles for 20 cycles, then stays low.
  - Response: btn_level, press_pulse and step_pulse all stay 0.
- Long press with auto-repeat:
  - Stimulus: btn_raw[1] held 100 cycles from edge 0.
  - Response: press at edge 5; long_pulse[1] and step_pulse[1] at edge 25.
  - Response: further step_pulse[1] at edges 33, 41, 49 and onward, every 8 cycles until release.
- Masked bit:
  - Stimulus: btn_raw[4] held 100 cycles.
  - Response: step_pulse[4] only at the press; long_pulse[4] once at the hold point; no repeats.
- Release racing terminal count:
  - Stimulus: release timed so the debounced fall coincides with the REPEATING terminal count.
  - Response: release_pulse asserts and no step_pulse that cycle; FSM is IDLE the next cycle.
- Reset mid-hold:
  - Stimulus: assert rst_n=0 while in REPEATING.
  - Response: all outputs 0 immediately.
  - Stimulus: deassert rst_n with the button still held.
  - Response: press_pulse after the debounce latency, then the normal hold sequence.

Source files
------------

// File: rtl/button_events.sv
// -----------------------------------------------------------------------------
// button_events
//
// Purpose:
//   Conditions the five raw push buttons of the clock (up, down, left, right,
//   middle) into clean events. Each bit is synchronised, debounced, and then
//   tracked by a small hold FSM. The FSM produces a long-press pulse and
//   auto-repeat pulses, so a held up/down button keeps stepping a value.
//
// Ports:
//   clk            in   1  system clock, rising edge
//   rst_n          in   1  asynchronous active-low reset
//   btn_raw        in   5  raw buttons, active-high, asynchronous
//                          (bit0 up, bit1 down, bit2 left, bit3 right, bit4 middle)
//   btn_level      out  5  debounced button levels
//   press_pulse    out  5  one-cycle pulse on debounced rising edge
//   release_pulse  out  5  one-cycle pulse on debounced falling edge
//   long_pulse     out  5  one-cycle pulse when a press reaches HOLD_CYCLES
//   step_pulse     out  5  press_pulse OR auto-repeat (repeat only where
//                          REPEAT_MASK is set)
// -----------------------------------------------------------------------------
module button_events #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000,
    parameter logic [4:0]  REPEAT_MASK     = 5'b00011
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] press_pulse,
    output logic [4:0] release_pulse,
    output logic [4:0] long_pulse,
    output logic [4:0] step_pulse
);

    localparam int unsigned NB     = 5;
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HR_W   = $clog2(HR_MAX);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);
    localparam logic [HR_W-1:0] HOLD_LAST = HR_W'(HOLD_CYCLES - 1);
    localparam logic [HR_W-1:0] REP_LAST  = HR_W'(REPEAT_CYCLES - 1);
    localparam logic [HR_W-1:0] HR_ONE    = HR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_REPEATING = 2'd2
    } state_t;

    logic [NB-1:0]   r_sync1;
    logic [NB-1:0]   r_sync2;
    logic [NB-1:0]   r_level;
    logic [NB-1:0]   r_press;
    logic [NB-1:0]   r_release;
    logic [NB-1:0]   r_long;
    logic [NB-1:0]   r_step;
    logic [DB_W-1:0] r_db_cnt   [NB];
    state_t          r_state    [NB];
    logic [HR_W-1:0] r_hold_cnt [NB];

    logic [NB-1:0]   w_differ;
    logic [NB-1:0]   w_db_done;
    logic [NB-1:0]   w_rise;
    logic [NB-1:0]   w_fall;
    logic [NB-1:0]   w_hold_tc;
    logic [NB-1:0]   w_rep_tc;
    logic [NB-1:0]   w_long;
    logic [NB-1:0]   w_repeat;

    // Terminal-count detection for debounce and hold/repeat counters.
    always_comb begin
        w_differ  = r_sync2 ^ r_level;
        w_db_done = '0;
        w_hold_tc = '0;
        w_rep_tc  = '0;
        for (int i = 0; i < NB; i++) begin
            w_db_done[i] = w_differ[i] && (r_db_cnt[i] == DB_LAST);
            w_hold_tc[i] = (r_state[i] == ST_PRESSED)   && (r_hold_cnt[i] == HOLD_LAST);
            w_rep_tc[i]  = (r_state[i] == ST_REPEATING) && (r_hold_cnt[i] == REP_LAST);
        end
    end

    assign w_rise   = w_db_done & r_sync2;
    assign w_fall   = w_db_done & ~r_sync2;
    // A debounced release in the same cycle as a terminal count suppresses
    // the long/repeat pulse: the user has already let go.
    assign w_long   = w_hold_tc & ~w_fall;
    assign w_repeat = (w_hold_tc | w_rep_tc) & ~w_fall;

    // Two-flop synchroniser; nothing else looks at btn_raw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: the counter runs only while the synchronised input disagrees
    // with the accepted level, so any glitch back restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < NB; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_press   <= w_rise;
            r_release <= w_fall;
            for (int i = 0; i < NB; i++) begin
                if (!w_differ[i] || w_db_done[i]) begin
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_ONE;
                end
                if (w_db_done[i]) begin
                    r_level[i] <= r_sync2[i];
                end
            end
        end
    end

    // Hold FSM per bit; one counter serves both the hold delay and the
    // repeat interval since the two phases never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_long <= '0;
            r_step <= '0;
            for (int i = 0; i < NB; i++) begin
                r_state[i]    <= ST_IDLE;
                r_hold_cnt[i] <= '0;
            end
        end else begin
            r_long <= w_long;
            r_step <= w_rise | (w_repeat & REPEAT_MASK);
            for (int i = 0; i < NB; i++) begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (w_rise[i]) begin
                            r_state[i]    <= ST_PRESSED;
                            r_hold_cnt[i] <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (w_fall[i]) begin
                            r_state[i]    <= ST_IDLE;
                            r_hold_cnt[i] <= '0;
                        end else if (w_hold_tc[i]) begin
                            r_state[i]    <= ST_REPEATING;
                            r_hold_cnt[i] <= '0;
                        end else begin
                            r_hold_cnt[i] <= r_hold_cnt[i] + HR_ONE;
                        end
                    end
                    ST_REPEATING: begin
                        if (w_fall[i]) begin
                            r_state[i]    <= ST_IDLE;
                            r_hold_cnt[i] <= '0;
                        end else if (w_rep_tc[i]) begin
                            r_hold_cnt[i] <= '0;
                        end else begin
                            r_hold_cnt[i] <= r_hold_cnt[i] + HR_ONE;
                        end
                    end
                    default: begin
                        r_state[i]    <= ST_IDLE;
                        r_hold_cnt[i] <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;
    assign step_pulse    = r_step;

endmodule

// File: tb/tb_button_events.sv
// -----------------------------------------------------------------------------
// tb_button_events
//
// Purpose:
//   Self-checking bench for button_events with short timing parameters.
//   A reference model derives the expected outputs from the raw sample history
//   and the age of each press. Scenario tasks compare the DUT against that
//   model on every cycle and add checks at the fixed edges of each scenario.
// -----------------------------------------------------------------------------
module tb_button_events;

    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn_raw = 5'b0;
    logic [4:0] btn_level, press_pulse, release_pulse, long_pulse, step_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    button_events #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R),
        .REPEAT_MASK    (5'b00011)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .step_pulse   (step_pulse)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The level flips at an edge when the D raw samples taken two to D+1 edges
    // earlier all disagree with it. Long/repeat pulses follow from press age.
    logic [4:0] m_mask  = 5'b00011;
    logic [4:0] m_hist [0:D+1];
    logic [4:0] m_level = '0, m_press = '0, m_rel = '0, m_long = '0, m_step = '0;
    logic [4:0] m_held  = '0;
    int         m_age [5];
    bit         mf, mrise, mfall, mrep;

    initial begin
        for (int k = 0; k <= D + 1; k++) m_hist[k] = '0;
        for (int b = 0; b < 5; b++) m_age[b] = 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= D + 1; k++) m_hist[k] = '0;
            m_level = '0; m_press = '0; m_rel = '0; m_long = '0; m_step = '0;
            m_held  = '0;
            for (int b = 0; b < 5; b++) m_age[b] = 0;
        end else begin
            for (int k = D + 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = btn_raw;
            for (int b = 0; b < 5; b++) begin
                mf = 1'b1;
                for (int k = 2; k <= D + 1; k++)
                    if (m_hist[k][b] == m_level[b]) mf = 1'b0;
                mrise = mf && !m_level[b];
                mfall = mf && m_level[b];
                mrep  = 1'b0;
                m_press[b] = mrise;
                m_rel[b]   = mfall;
                m_long[b]  = 1'b0;
                if (mf) m_level[b] = ~m_level[b];
                if (mrise) begin
                    m_held[b] = 1'b1;
                    m_age[b]  = 0;
                end else if (m_held[b]) begin
                    m_age[b] = m_age[b] + 1;
                    if (mfall) begin
                        m_held[b] = 1'b0;
                    end else if (m_age[b] >= H && ((m_age[b] - H) % R) == 0) begin
                        mrep      = 1'b1;
                        m_long[b] = (m_age[b] == H);
                    end
                end
                m_step[b] = mrise | (mrep & m_mask[b]);
            end
        end
    end

    function automatic logic [24:0] got_v();
        return {btn_level, press_pulse, release_pulse, long_pulse, step_pulse};
    endfunction

    function automatic logic [24:0] exp_v();
        return {m_level, m_press, m_rel, m_long, m_step};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n   = 1'b0;
        btn_raw = 5'h1f;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (got_v() !== 25'h0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h required %h", i, got_v(), 25'h0);
            end
        end
        btn_raw = 5'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (got_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %h required %h", i, got_v(), exp_v());
            end
        end
    endtask

    task automatic test_clean_press();
        btn_raw[0] = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            n_tests++;
            if (got_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL clean_model edge %0d: got %h required %h", i, got_v(), exp_v());
            end
            if (i == 4) begin
                n_tests++;
                if ({btn_level[0], press_pulse[0]} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL clean_early edge 4: got %b required 00", {btn_level[0], press_pulse[0]});
                end
            end
            if (i == 5) begin
                n_tests++;
                if ({btn_level[0], press_pulse[0], step_pulse[0]} !== 3'b111) begin
                    n_fail++;
                    $display("FAIL clean_press edge 5: got %b required 111",
                             {btn_level[0], press_pulse[0], step_pulse[0]});
                end
            end
            if (i == 6) begin
                n_tests++;
                if ({press_pulse[0], step_pulse[0]} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL clean_one_cycle edge 6: got %b required 00", {press_pulse[0], step_pulse[0]});
                end
            end
            if (i == 55) begin
                n_tests++;
                if ({btn_level[0], release_pulse[0], press_pulse[0]} !== 3'b010) begin
                    n_fail++;
                    $display("FAIL clean_release edge 55: got %b required 010",
                             {btn_level[0], release_pulse[0], press_pulse[0]});
                end
            end
            if (i == 49) btn_raw[0] = 1'b0;
        end
    endtask

    task automatic test_bounce();
        int seen;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            btn_raw[2] = (i < 20) ? (((i / 2) % 2) == 0) : 1'b0;
            @(negedge clk);
            n_tests++;
            if (got_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL bounce_model edge %0d: got %h required %h", i, got_v(), exp_v());
            end
            if (btn_level[2] || press_pulse[2] || step_pulse[2]) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL bounce_reject: got %0d active cycles required 0", seen);
        end
    endtask

    task automatic test_long_repeat();
        btn_raw[1] = 1'b1;
        for (int i = 0; i < 115; i++) begin
            @(negedge clk);
            n_tests++;
            if (got_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL repeat_model edge %0d: got %h required %h", i, got_v(), exp_v());
            end
            if (i == 25) begin
                n_tests++;
                if ({long_pulse[1], step_pulse[1]} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL long_point edge 25: got %b required 11", {long_pulse[1], step_pulse[1]});
                end
            end
            if (i == 33 || i == 41 || i == 49) begin
                n_tests++;
                if ({long_pulse[1], step_pulse[1]} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL repeat_step edge %0d: got %b required 01", i, {long_pulse[1], step_pulse[1]});
                end
            end
            if (i == 34) begin
                n_tests++;
                if (step_pulse[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL repeat_gap edge 34: got %b required 0", step_pulse[1]);
                end
            end
            if (i == 99) btn_raw[1] = 1'b0;
        end
    endtask

    task automatic test_masked();
        int n_step, n_long;
        n_step = 0; n_long = 0;
        btn_raw[4] = 1'b1;
        for (int i = 0; i < 115; i++) begin
            @(negedge clk);
            n_tests++;
            if (got_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL masked_model edge %0d: got %h required %h", i, got_v(), exp_v());
            end
            if (step_pulse[4]) n_step++;
            if (long_pulse[4]) n_long++;
            if (i == 25) begin
                n_tests++;
                if ({long_pulse[4], step_pulse[4]} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL masked_long edge 25: got %b required 10", {long_pulse[4], step_pulse[4]});
                end
            end
            if (i == 99) btn_raw[4] = 1'b0;
        end
        n_tests++;
        if (n_step !== 1 || n_long !== 1) begin
            n_fail++;
            $display("FAIL masked_counts: got step=%0d long=%0d required step=1 long=1", n_step, n_long);
        end
    endtask

    task automatic test_release_race();
        // Press edge 5, repeats at 33, 41, 49; raw drops at edge 36 so the
        // debounced fall lands on edge 41.
        btn_raw[1] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n_tests++;
            if (got_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL race_model edge %0d: got %h required %h", i, got_v(), exp_v());
            end
            if (i == 41) begin
                n_tests++;
                if ({release_pulse[1], step_pulse[1], long_pulse[1]} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL race_release edge 41: got %b required 100",
                             {release_pulse[1], step_pulse[1], long_pulse[1]});
                end
            end
            if (i == 49) begin
                n_tests++;
                if (step_pulse[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL race_idle edge 49: got %b required 0", step_pulse[1]);
                end
            end
            if (i == 35) btn_raw[1] = 1'b0;
        end
    endtask

    task automatic test_reset_mid_hold();
        btn_raw = 5'b00011;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_tests++;
            if (got_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL midrst_pre edge %0d: got %h required %h", i, got_v(), exp_v());
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (got_v() !== 25'h0) begin
            n_fail++;
            $display("FAIL midrst_async: got %h required %h", got_v(), 25'h0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_tests++;
            if (got_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL midrst_post edge %0d: got %h required %h", i, got_v(), exp_v());
            end
            if (i == 4 || i == 5) begin
                n_tests++;
                if (press_pulse[1:0] !== ((i == 5) ? 2'b11 : 2'b00)) begin
                    n_fail++;
                    $display("FAIL midrst_repress edge %0d: got %b required %b", i, press_pulse[1:0],
                             (i == 5) ? 2'b11 : 2'b00);
                end
            end
            if (i == 25) begin
                n_tests++;
                if (long_pulse[1:0] !== 2'b11) begin
                    n_fail++;
                    $display("FAIL midrst_long edge 25: got %b required 11", long_pulse[1:0]);
                end
            end
        end
        btn_raw = 5'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if (got_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL midrst_tail edge %0d: got %h required %h", i, got_v(), exp_v());
            end
        end
    endtask

    task automatic test_back_to_back();
        btn_raw = 5'h1f;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            n_tests++;
            if (got_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL b2b_model edge %0d: got %h required %h", i, got_v(), exp_v());
            end
            if (i == 5 || i == 25) begin
                n_tests++;
                if ({press_pulse, step_pulse} !== 10'h3ff) begin
                    n_fail++;
                    $display("FAIL b2b_press edge %0d: got %h required %h", i, {press_pulse, step_pulse}, 10'h3ff);
                end
            end
            if (i == 15) begin
                n_tests++;
                if ({release_pulse, btn_level} !== 10'h3e0) begin
                    n_fail++;
                    $display("FAIL b2b_release edge 15: got %h required %h", {release_pulse, btn_level}, 10'h3e0);
                end
            end
            if (i == 9)  btn_raw = 5'h00;
            if (i == 19) btn_raw = 5'h1f;
            if (i == 29) btn_raw = 5'h00;
        end
    endtask

    task automatic test_random();
        int rem [5];
        int r;
        for (int b = 0; b < 5; b++) rem[b] = $urandom_range(1, 30);
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 5; b++) begin
                if (rem[b] == 0) begin
                    btn_raw[b] = ~btn_raw[b];
                    r = $urandom_range(0, 9);
                    if (r < 3)      rem[b] = $urandom_range(1, 3);
                    else if (r < 6) rem[b] = $urandom_range(4, 12);
                    else            rem[b] = $urandom_range(20, 70);
                end else begin
                    rem[b] = rem[b] - 1;
                end
            end
            @(negedge clk);
            n_tests++;
            if (got_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL random_model cycle %0d: got %h required %h", i, got_v(), exp_v());
            end
        end
        btn_raw = 5'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_tests++;
            if (got_v() !== exp_v()) begin
                n_fail++;
                $display("FAIL random_tail cycle %0d: got %h required %h", i, got_v(), exp_v());
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_masked();
        test_release_race();
        test_reset_mid_hold();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
